// File: rtl/width_conv_fifo_pkg.sv
// Shared sizing helpers and lane-order constants for the width-converting FIFO.
package width_conv_fifo_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

  localparam int unsigned MAX_RATIO_LOG2 = 5;

  function automatic int unsigned wide_w(input int unsigned wr_w, input int unsigned rd_w);
    return (wr_w >= rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int unsigned narrow_w(input int unsigned wr_w, input int unsigned rd_w);
    return (wr_w >= rd_w) ? rd_w : wr_w;
  endfunction

  function automatic int unsigned ratio(input int unsigned wr_w, input int unsigned rd_w);
    return wide_w(wr_w, rd_w) / narrow_w(wr_w, rd_w);
  endfunction

  function automatic int unsigned ratio_log2(input int unsigned wr_w, input int unsigned rd_w);
    return $clog2(ratio(wr_w, rd_w));
  endfunction

  // Wide side must be the narrow side times 2^k, k <= MAX_RATIO_LOG2
  function automatic bit ratio_ok(input int unsigned wr_w, input int unsigned rd_w);
    int unsigned r;
    r = ratio(wr_w, rd_w);
    return (narrow_w(wr_w, rd_w) != 0) && (r * narrow_w(wr_w, rd_w) == wide_w(wr_w, rd_w)) &&
           ((r & (r - 1)) == 0) && (ratio_log2(wr_w, rd_w) <= MAX_RATIO_LOG2);
  endfunction

  function automatic int unsigned wr_lvl_w(input int unsigned wr_w, input int unsigned rd_w,
                                           input int unsigned depth_w);
    return (wr_w >= rd_w) ? depth_w + 1 : depth_w + ratio_log2(wr_w, rd_w) + 1;
  endfunction

  function automatic int unsigned rd_lvl_w(input int unsigned wr_w, input int unsigned rd_w,
                                           input int unsigned depth_w);
    return (rd_w >= wr_w) ? depth_w + 1 : depth_w + ratio_log2(wr_w, rd_w) + 1;
  endfunction

endpackage

// File: rtl/width_conv_sync_fifo_if.sv
// Write/read handshake, levels and status flags of the width-converting FIFO.
interface width_conv_sync_fifo_if
  import width_conv_fifo_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH = 256,
  parameter int unsigned RD_DATA_WIDTH = 32,
  parameter int unsigned DEPTH_WIDTH   = 8
);
  localparam int unsigned WR_LVL_W = wr_lvl_w(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH);
  localparam int unsigned RD_LVL_W = rd_lvl_w(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH);

  logic                     flush;
  logic                     wr_en;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_full;
  logic                     almost_full;
  logic [WR_LVL_W-1:0]      wr_water_level;
  logic                     wr_overflow;
  logic                     rd_en;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_empty;
  logic                     almost_empty;
  logic [RD_LVL_W-1:0]      rd_water_level;
  logic                     rd_underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_full, almost_full, wr_water_level, wr_overflow,
    input  rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_full, almost_full, wr_water_level, wr_overflow,
    output rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
  );
endinterface

// File: rtl/width_conv_fifo_ram.sv
// Simple dual-port wide-word RAM; read port forwards a same-cycle write to the read address.
module width_conv_fifo_ram #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end
endmodule

// File: rtl/width_conv_sync_fifo.sv
// Single-clock FIFO converting between a wide and a narrow bus (up- or downsizing),
// with water levels, almost flags, sticky error flags and synchronous flush.
module width_conv_sync_fifo
  import width_conv_fifo_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH    = 256,
  parameter int unsigned RD_DATA_WIDTH    = 32,
  parameter int unsigned DEPTH_WIDTH      = 8,
  parameter int unsigned ALMOST_FULL_NUM  = 124,
  parameter int unsigned ALMOST_EMPTY_NUM = 4,
  parameter string       LANE_ORDER       = "LSB_FIRST"
) (
  input logic                  clk,
  input logic                  rst,
  width_conv_sync_fifo_if.slave bus
);
  localparam int unsigned WIDE_W       = wide_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int unsigned NARROW_W     = narrow_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int unsigned R            = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int unsigned RL           = ratio_log2(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int unsigned LW           = (RL == 0) ? 1 : RL;
  localparam int unsigned CNT_W        = DEPTH_WIDTH + 1;
  localparam int unsigned NARROW_LVL_W = DEPTH_WIDTH + RL + 1;
  localparam int unsigned WR_LVL_W     = wr_lvl_w(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH);
  localparam int unsigned RD_LVL_W     = rd_lvl_w(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH);
  localparam int unsigned DEPTH        = 2 ** DEPTH_WIDTH;
  localparam bit          DOWNSIZE     = (WR_DATA_WIDTH >= RD_DATA_WIDTH);
  localparam lane_order_e ORDER        = (LANE_ORDER == "MSB_FIRST") ? LANE_MSB_FIRST : LANE_LSB_FIRST;

  if (!ratio_ok(WR_DATA_WIDTH, RD_DATA_WIDTH)) begin : g_bad_ratio
    $error("width_conv_sync_fifo: wide width must be narrow width times 2^k, k in 0..5");
  end

  // Bit offset of narrow lane 'lane' inside a wide word
  function automatic int unsigned lane_base(input int unsigned lane);
    return ((ORDER == LANE_MSB_FIRST) ? (R - 1 - lane) : lane) * NARROW_W;
  endfunction

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic                     wr_ovf_q, rd_unf_q;
  logic [RD_DATA_WIDTH-1:0] rd_data_q;
  logic                     full, empty, wr_acc, rd_acc;
  logic                     commit, free, lane_step, lane_last;
  logic [WIDE_W-1:0]        ram_wdata, ram_q;
  logic [RD_DATA_WIDTH-1:0] rd_word;
  logic [WR_LVL_W-1:0]      wr_lvl;
  logic [RD_LVL_W-1:0]      rd_lvl;
  logic [NARROW_LVL_W-1:0]  narrow_base;

  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign empty       = (rd_lvl == '0);
  assign wr_acc      = bus.wr_en & ~full & ~bus.flush;
  assign rd_acc      = bus.rd_en & ~empty & ~bus.flush;
  assign lane_last   = (lane_q == LW'(R - 1));
  assign narrow_base = NARROW_LVL_W'(cnt_q) << RL;

  if (DOWNSIZE) begin : g_down
    // Lane counter walks the head entry; entry retires on its last lane
    assign commit    = wr_acc;
    assign lane_step = rd_acc;
    assign free      = rd_acc & lane_last;
    assign ram_wdata = bus.wr_data;
    assign wr_lvl    = WR_LVL_W'(cnt_q);
    assign rd_lvl    = RD_LVL_W'(narrow_base - NARROW_LVL_W'(lane_q));

    always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < R; i++)
        if (lane_q == LW'(i)) rd_word = ram_q[lane_base(i) +: NARROW_W];
    end
  end else begin : g_up
    logic [WIDE_W-1:0] pack_q, pack_d;

    // Lane counter fills the pack register; entry commits on its last lane
    assign commit    = wr_acc & lane_last;
    assign lane_step = wr_acc;
    assign free      = rd_acc;
    assign ram_wdata = pack_d;
    assign rd_word   = ram_q;
    assign wr_lvl    = WR_LVL_W'(narrow_base + NARROW_LVL_W'(lane_q));
    assign rd_lvl    = RD_LVL_W'(cnt_q);

    always_comb begin
      pack_d = pack_q;
      for (int unsigned i = 0; i < R; i++)
        if (lane_q == LW'(i)) pack_d[lane_base(i) +: NARROW_W] = bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)            pack_q <= '0;
      else if (bus.flush) pack_q <= '0;
      else if (wr_acc)    pack_q <= pack_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    if (bus.flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lane_d   = '0;
    end else begin
      if (commit)    wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
      if (free)      rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
      if (lane_step) lane_d   = lane_last ? '0 : lane_q + LW'(1);
      case ({commit, free})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lane_q    <= '0;
      wr_ovf_q  <= 1'b0;
      rd_unf_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      if (bus.flush) begin
        wr_ovf_q  <= 1'b0;
        rd_unf_q  <= 1'b0;
        rd_data_q <= '0;
      end else begin
        if (bus.wr_en && full)  wr_ovf_q  <= 1'b1;
        if (bus.rd_en && empty) rd_unf_q  <= 1'b1;
        if (rd_acc)             rd_data_q <= rd_word;
      end
    end
  end

  // Read address runs one step ahead so ram_q always holds the current head entry
  width_conv_fifo_ram #(
    .WIDTH (WIDE_W),
    .AW    (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .raddr (rd_ptr_d),
    .rdata (ram_q)
  );

  assign bus.wr_full        = full;
  assign bus.almost_full    = (wr_lvl >= WR_LVL_W'(ALMOST_FULL_NUM));
  assign bus.wr_water_level = wr_lvl;
  assign bus.wr_overflow    = wr_ovf_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_empty       = empty;
  assign bus.almost_empty   = (rd_lvl <= RD_LVL_W'(ALMOST_EMPTY_NUM));
  assign bus.rd_water_level = rd_lvl;
  assign bus.rd_underflow   = rd_unf_q;
endmodule

// File: tb/tb_width_conv_sync_fifo.sv
// Directed bench: vector table on a 256->32 LSB_FIRST FIFO plus hand sequences for
// fill/overflow, flush, reset, 32->256 upsizing and MSB_FIRST downsizing.
module tb_width_conv_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  width_conv_sync_fifo_if #(.WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(8)) dn_if ();
  width_conv_sync_fifo_if #(.WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(4)) ms_if ();
  width_conv_sync_fifo_if #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(256), .DEPTH_WIDTH(4)) up_if ();

  width_conv_sync_fifo #(
    .WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(8),
    .ALMOST_FULL_NUM(124), .ALMOST_EMPTY_NUM(4), .LANE_ORDER("LSB_FIRST")
  ) u_dn (.clk(clk), .rst(rst), .bus(dn_if.slave));

  width_conv_sync_fifo #(
    .WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(4),
    .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(4), .LANE_ORDER("MSB_FIRST")
  ) u_ms (.clk(clk), .rst(rst), .bus(ms_if.slave));

  width_conv_sync_fifo #(
    .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(256), .DEPTH_WIDTH(4),
    .ALMOST_FULL_NUM(100), .ALMOST_EMPTY_NUM(1), .LANE_ORDER("LSB_FIRST")
  ) u_up (.clk(clk), .rst(rst), .bus(up_if.slave));

  typedef struct {
    logic         wr_en;
    logic         rd_en;
    logic         flush;
    logic [255:0] wr_data;
    logic [31:0]  exp_rd_data;
    int unsigned  exp_rd_lvl;
    int unsigned  exp_wr_lvl;
    logic         exp_empty;
    logic         exp_almost_empty;
    logic         exp_underflow;
  } vec_t;

  vec_t         vecs[16];
  int unsigned  n_total = 0;
  int unsigned  n_pass  = 0;
  logic [255:0] w_seq;
  logic [255:0] w_ent;
  logic [255:0] up_exp;

  function automatic vec_t mk(input logic we, input logic re, input logic fl,
                              input logic [255:0] d, input logic [31:0] rdd,
                              input int unsigned rl, input int unsigned wl,
                              input logic e, input logic ae, input logic uf);
    vec_t v;
    v.wr_en = we; v.rd_en = re; v.flush = fl; v.wr_data = d;
    v.exp_rd_data = rdd; v.exp_rd_lvl = rl; v.exp_wr_lvl = wl;
    v.exp_empty = e; v.exp_almost_empty = ae; v.exp_underflow = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dn_drive(input logic we, input logic re, input logic fl, input logic [255:0] d);
    dn_if.wr_en = we; dn_if.rd_en = re; dn_if.flush = fl; dn_if.wr_data = d;
  endtask

  task automatic chk_dn_reset(input string tag);
    chk({tag, " wr_full"},        256'(dn_if.wr_full),        256'(0));
    chk({tag, " almost_full"},    256'(dn_if.almost_full),    256'(0));
    chk({tag, " wr_lvl"},         256'(dn_if.wr_water_level), 256'(0));
    chk({tag, " wr_overflow"},    256'(dn_if.wr_overflow),    256'(0));
    chk({tag, " rd_data"},        256'(dn_if.rd_data),        256'(0));
    chk({tag, " rd_empty"},       256'(dn_if.rd_empty),       256'(1));
    chk({tag, " almost_empty"},   256'(dn_if.almost_empty),   256'(1));
    chk({tag, " rd_lvl"},         256'(dn_if.rd_water_level), 256'(0));
    chk({tag, " rd_underflow"},   256'(dn_if.rd_underflow),   256'(0));
  endtask

  initial begin
    dn_drive(1'b0, 1'b0, 1'b0, '0);
    ms_if.wr_en = 1'b0; ms_if.rd_en = 1'b0; ms_if.flush = 1'b0; ms_if.wr_data = '0;
    up_if.wr_en = 1'b0; up_if.rd_en = 1'b0; up_if.flush = 1'b0; up_if.wr_data = '0;

    for (int j = 0; j < 8; j++) w_seq[j*32 +: 32] = 32'(j);

    // Table: one cycle per entry on the 256->32 LSB_FIRST instance
    vecs[0] = mk(1, 0, 0, w_seq, 32'd0, 8, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      vecs[k] = mk(0, 1, 0, '0, 32'(k - 1), 32'(8 - k), (k < 8) ? 1 : 0,
                   (k == 8), ((8 - k) <= 4), 0);
    vecs[9]  = mk(0, 1, 0, '0,    32'd7, 0,  0, 1, 1, 1);
    vecs[10] = mk(0, 0, 1, '0,    32'd0, 0,  0, 1, 1, 0);
    vecs[11] = mk(1, 0, 0, w_seq, 32'd0, 8,  1, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, w_seq, 32'd0, 15, 2, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, '0,    32'd1, 14, 2, 0, 0, 0);
    vecs[14] = mk(1, 1, 1, w_seq, 32'd0, 0,  0, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, '0,    32'd0, 0,  0, 1, 1, 0);

    repeat (3) tick();
    chk_dn_reset("in_reset");
    rst = 1'b0;
    tick();
    chk_dn_reset("after_reset");

    for (int i = 0; i < 16; i++) begin
      dn_drive(vecs[i].wr_en, vecs[i].rd_en, vecs[i].flush, vecs[i].wr_data);
      tick();
      chk($sformatf("vec%0d rd_data", i),      256'(dn_if.rd_data),        256'(vecs[i].exp_rd_data));
      chk($sformatf("vec%0d rd_lvl", i),       256'(dn_if.rd_water_level), 256'(vecs[i].exp_rd_lvl));
      chk($sformatf("vec%0d wr_lvl", i),       256'(dn_if.wr_water_level), 256'(vecs[i].exp_wr_lvl));
      chk($sformatf("vec%0d rd_empty", i),     256'(dn_if.rd_empty),       256'(vecs[i].exp_empty));
      chk($sformatf("vec%0d almost_empty", i), 256'(dn_if.almost_empty),   256'(vecs[i].exp_almost_empty));
      chk($sformatf("vec%0d rd_underflow", i), 256'(dn_if.rd_underflow),   256'(vecs[i].exp_underflow));
    end
    dn_drive(1'b0, 1'b0, 1'b0, '0);

    // Fill to full, then overflow; first entry must survive
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 8; j++) w_ent[j*32 +: 32] = {16'(i), 16'(j)};
      dn_drive(1'b1, 1'b0, 1'b0, w_ent);
      tick();
      if (i == 122 || i == 123 || i == 255) begin
        chk($sformatf("fill%0d almost_full", i + 1), 256'(dn_if.almost_full), 256'(1'((i + 1) >= 124)));
        chk($sformatf("fill%0d wr_lvl", i + 1), 256'(dn_if.wr_water_level), 256'(i + 1));
        chk($sformatf("fill%0d wr_full", i + 1), 256'(dn_if.wr_full), 256'(1'(i == 255)));
      end
    end
    dn_drive(1'b1, 1'b0, 1'b0, {256{1'b1}});
    tick();
    chk("ovf wr_overflow", 256'(dn_if.wr_overflow),    256'(1));
    chk("ovf wr_lvl",      256'(dn_if.wr_water_level), 256'(256));
    chk("ovf rd_lvl",      256'(dn_if.rd_water_level), 256'(2048));
    for (int j = 0; j < 8; j++) begin
      dn_drive(1'b0, 1'b1, 1'b0, '0);
      tick();
      chk($sformatf("head lane%0d", j), 256'(dn_if.rd_data), 256'({16'd0, 16'(j)}));
    end
    chk("drain1 wr_lvl",  256'(dn_if.wr_water_level), 256'(255));
    chk("drain1 wr_full", 256'(dn_if.wr_full),        256'(0));
    dn_drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("flush wr_overflow", 256'(dn_if.wr_overflow),    256'(0));
    chk("flush wr_lvl",      256'(dn_if.wr_water_level), 256'(0));

    // Three entries stored, flush together with write and read
    for (int i = 0; i < 3; i++) begin
      dn_drive(1'b1, 1'b0, 1'b0, w_seq);
      tick();
    end
    chk("three wr_lvl", 256'(dn_if.wr_water_level), 256'(3));
    dn_drive(1'b1, 1'b1, 1'b1, w_seq);
    tick();
    chk("flushwr wr_lvl",   256'(dn_if.wr_water_level), 256'(0));
    chk("flushwr rd_lvl",   256'(dn_if.rd_water_level), 256'(0));
    chk("flushwr rd_empty", 256'(dn_if.rd_empty),       256'(1));
    dn_drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("postflush rd_empty", 256'(dn_if.rd_empty), 256'(1));

    // Three entries stored plus a read in flight, then asynchronous reset
    for (int j = 0; j < 8; j++) w_ent[j*32 +: 32] = {16'h0055, 16'(j + 1)};
    for (int i = 0; i < 3; i++) begin
      dn_drive(1'b1, 1'b0, 1'b0, w_ent);
      tick();
    end
    dn_drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    chk("prerst rd_data", 256'(dn_if.rd_data), 256'(32'h0055_0001));
    dn_drive(1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    chk_dn_reset("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_dn_reset("post_rst");

    // Upsize 32->256: seven lanes stay hidden, the eighth commits
    for (int j = 0; j < 8; j++) up_exp[j*32 +: 32] = 32'hA000_0000 + 32'(j);
    for (int j = 0; j < 7; j++) begin
      up_if.wr_en = 1'b1; up_if.wr_data = 32'hA000_0000 + 32'(j);
      tick();
    end
    chk("up7 rd_empty", 256'(up_if.rd_empty),       256'(1));
    chk("up7 wr_lvl",   256'(up_if.wr_water_level), 256'(7));
    chk("up7 rd_lvl",   256'(up_if.rd_water_level), 256'(0));
    up_if.wr_data = 32'hA000_0007;
    tick();
    up_if.wr_en = 1'b0;
    chk("up8 rd_lvl",   256'(up_if.rd_water_level), 256'(1));
    chk("up8 rd_empty", 256'(up_if.rd_empty),       256'(0));
    chk("up8 wr_lvl",   256'(up_if.wr_water_level), 256'(8));
    up_if.rd_en = 1'b1;
    tick();
    up_if.rd_en = 1'b0;
    chk("up rd_data",     256'(up_if.rd_data),        up_exp);
    chk("up rd_empty",    256'(up_if.rd_empty),       256'(1));
    chk("up wr_lvl_done", 256'(up_if.wr_water_level), 256'(0));

    // MSB_FIRST downsize: value 1 lives in the last lane read
    ms_if.wr_en = 1'b1; ms_if.wr_data = 256'd1;
    tick();
    ms_if.wr_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ms_if.rd_en = 1'b1;
      tick();
      chk($sformatf("msb lane%0d", j), 256'(ms_if.rd_data), 256'((j == 7) ? 1 : 0));
    end
    ms_if.rd_en = 1'b0;
    chk("msb rd_empty", 256'(ms_if.rd_empty), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
